// File: rtl/prio_decoder_3x8_dispatch.sv
// Decodes the 3-bit encoder code into an 8-bit pending request set and dispatches
// pending requests one at a time, highest index first, on a one-hot valid/ready channel.
module prio_decoder_3x8_dispatch #(
   parameter int DROP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        in_code,
   input  logic              in_idle,
   input  logic              in_valid,
   output logic [7:0]        out_onehot,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        pending,
   output logic [DROP_W-1:0] drop_cnt,
   input  logic              clr_drops
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   state_t              state_q, state_d;
   logic [7:0]          pending_q, pending_d;
   logic [7:0]          out_onehot_q, out_onehot_d;
   logic                out_valid_q, out_valid_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic                accept;
   logic                handshake;
   logic                dup;
   logic [7:0]          set_vec;
   logic [7:0]          clr_vec;

   function automatic logic [7:0] decode3(input logic [2:0] code);
      return 8'b1 << code;
   endfunction

   // Later (higher) indices overwrite earlier ones, so the result is the top set bit.
   function automatic logic [7:0] highest_bit(input logic [7:0] vec);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (vec[i]) r = 8'b1 << i;
      end
      return r;
   endfunction

   always_comb begin
      accept    = in_valid & ~in_idle;
      handshake = out_valid_q & out_ready;
      set_vec   = accept ? decode3(in_code) : 8'h00;
      clr_vec   = handshake ? out_onehot_q : 8'h00;
      // A set that lands on a bit being retired this edge is a fresh request, not a merge.
      dup       = |(pending_q & set_vec & ~clr_vec);
      pending_d = (pending_q & ~clr_vec) | set_vec;

      drop_cnt_d = drop_cnt_q;
      if (clr_drops) begin
         drop_cnt_d = '0;
      end else if (dup && (drop_cnt_q != DROP_MAX)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end

      state_d      = state_q;
      out_onehot_d = out_onehot_q;
      out_valid_d  = out_valid_q;
      case (state_q)
         IDLE: begin
            if (pending_q != 8'h00) begin
               out_onehot_d = highest_bit(pending_q);
               out_valid_d  = 1'b1;
               state_d      = PRESENT;
            end
         end
         PRESENT: begin
            if (handshake) begin
               out_onehot_d = 8'h00;
               out_valid_d  = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            out_onehot_d = 8'h00;
            out_valid_d  = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pending_q    <= 8'h00;
         out_onehot_q <= 8'h00;
         out_valid_q  <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         out_onehot_q <= out_onehot_d;
         out_valid_q  <= out_valid_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign out_onehot = out_onehot_q;
   assign out_valid  = out_valid_q;
   assign pending    = pending_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_prio_decoder_3x8_dispatch.sv
// Self-checking bench for prio_decoder_3x8_dispatch: directed vector table,
// hand-written saturation/reset sequences and a randomized run against a reference model.
module tb_prio_decoder_3x8_dispatch;

   localparam int DROP_W = 4;
   localparam int DROP_MAX = 15;
   localparam logic L0 = 1'b0;
   localparam logic L1 = 1'b1;

   logic              clk;
   logic              rst_n;
   logic [2:0]        in_code;
   logic              in_idle;
   logic              in_valid;
   logic [7:0]        out_onehot;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        pending;
   logic [DROP_W-1:0] drop_cnt;
   logic              clr_drops;

   int checks = 0;
   int errors = 0;

   prio_decoder_3x8_dispatch #(.DROP_W(DROP_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_code    (in_code),
      .in_idle    (in_idle),
      .in_valid   (in_valid),
      .out_onehot (out_onehot),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .pending    (pending),
      .drop_cnt   (drop_cnt),
      .clr_drops  (clr_drops)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [2:0] code;
      logic       idle;
      logic       valid;
      logic       ready;
      logic       clr;
      logic [7:0] e_onehot;
      logic       e_valid;
      logic [7:0] e_pend;
      logic [3:0] e_drop;
   } vec_t;

   vec_t vecs[26];

   // Reference model: set of pending indices, index being presented (-1 = none), drop count.
   bit m_pend[8];
   int m_cur;
   int m_drops;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] c, input logic idl, input logic vld,
                        input logic rdy, input logic clr);
      @(negedge clk);
      in_code   = c;
      in_idle   = idl;
      in_valid  = vld;
      out_ready = rdy;
      clr_drops = clr;
   endtask

   task automatic step(input logic [2:0] c, input logic idl, input logic vld,
                       input logic rdy, input logic clr);
      drive(c, idl, vld, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      m_cur   = -1;
      m_drops = 0;
   endtask

   task automatic model_step();
      bit hs;
      bit acc;
      bit old_pend[8];
      int k;
      k   = int'(in_code);
      hs  = (m_cur >= 0) && out_ready;
      acc = in_valid && !in_idle;
      for (int i = 0; i < 8; i++) old_pend[i] = m_pend[i];
      if (clr_drops) m_drops = 0;
      else if (acc && old_pend[k] && !(hs && m_cur == k) && m_drops < DROP_MAX) m_drops++;
      if (hs) m_pend[m_cur] = 1'b0;
      if (acc) m_pend[k] = 1'b1;
      if (hs) begin
         m_cur = -1;
      end else if (m_cur < 0) begin
         for (int i = 0; i < 8; i++) if (old_pend[i]) m_cur = i;
      end
   endtask

   function automatic logic [7:0] model_pend_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{3'd5, L0, L1, L1, L0, 8'h00, L0, 8'h20, 4'd0};
      vecs[1]  = '{3'd0, L0, L0, L1, L0, 8'h20, L1, 8'h20, 4'd0};
      vecs[2]  = '{3'd0, L0, L0, L1, L0, 8'h00, L0, 8'h00, 4'd0};
      vecs[3]  = '{3'd0, L0, L0, L1, L0, 8'h00, L0, 8'h00, 4'd0};
      vecs[4]  = '{3'd1, L0, L1, L0, L0, 8'h00, L0, 8'h02, 4'd0};
      vecs[5]  = '{3'd6, L0, L1, L0, L0, 8'h02, L1, 8'h42, 4'd0};
      vecs[6]  = '{3'd3, L0, L1, L0, L0, 8'h02, L1, 8'h4A, 4'd0};
      vecs[7]  = '{3'd0, L0, L0, L0, L0, 8'h02, L1, 8'h4A, 4'd0};
      vecs[8]  = '{3'd0, L0, L0, L1, L0, 8'h00, L0, 8'h48, 4'd0};
      vecs[9]  = '{3'd0, L0, L0, L1, L0, 8'h40, L1, 8'h48, 4'd0};
      vecs[10] = '{3'd0, L0, L0, L1, L0, 8'h00, L0, 8'h08, 4'd0};
      vecs[11] = '{3'd0, L0, L0, L1, L0, 8'h08, L1, 8'h08, 4'd0};
      vecs[12] = '{3'd0, L0, L0, L1, L0, 8'h00, L0, 8'h00, 4'd0};
      for (int i = 13; i < 18; i++)
         vecs[i] = '{3'd7, L1, L1, L1, L0, 8'h00, L0, 8'h00, 4'd0};
      vecs[18] = '{3'd4, L0, L1, L0, L0, 8'h00, L0, 8'h10, 4'd0};
      vecs[19] = '{3'd0, L0, L0, L0, L0, 8'h10, L1, 8'h10, 4'd0};
      vecs[20] = '{3'd4, L0, L1, L1, L0, 8'h00, L0, 8'h10, 4'd0};
      vecs[21] = '{3'd0, L0, L0, L1, L0, 8'h10, L1, 8'h10, 4'd0};
      vecs[22] = '{3'd0, L0, L0, L1, L0, 8'h00, L0, 8'h00, 4'd0};
      vecs[23] = '{3'd2, L0, L1, L0, L0, 8'h00, L0, 8'h04, 4'd0};
      vecs[24] = '{3'd2, L0, L1, L0, L0, 8'h04, L1, 8'h04, 4'd1};
      vecs[25] = '{3'd2, L0, L1, L0, L1, 8'h04, L1, 8'h04, 4'd0};

      rst_n = 1'b0; in_code = 3'd0; in_idle = 1'b1; in_valid = 1'b0;
      out_ready = 1'b0; clr_drops = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_onehot", 32'(out_onehot), 32'h0);
      chk("reset_valid",  32'(out_valid),  32'h0);
      chk("reset_pending", 32'(pending),   32'h0);
      chk("reset_drop",   32'(drop_cnt),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         step(vecs[i].code, vecs[i].idle, vecs[i].valid, vecs[i].ready, vecs[i].clr);
         chk($sformatf("vec%0d_onehot", i), 32'(out_onehot), 32'(vecs[i].e_onehot));
         chk($sformatf("vec%0d_valid", i),  32'(out_valid),  32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_pending", i), 32'(pending),   32'(vecs[i].e_pend));
         chk($sformatf("vec%0d_drop", i),   32'(drop_cnt),   32'(vecs[i].e_drop));
      end

      // Saturation: 20 duplicates of code 2 while it sits presented and unacknowledged.
      for (int i = 0; i < 20; i++) step(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("sat_drop", 32'(drop_cnt), 32'd15);
      chk("sat_hold_onehot", 32'(out_onehot), 32'h04);
      step(3'd2, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("clr_wins_drop", 32'(drop_cnt), 32'd0);
      step(3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("recount_drop", 32'(drop_cnt), 32'd1);
      step(3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("drain_pending", 32'(pending), 32'h0);
      chk("drain_valid", 32'(out_valid), 32'h0);

      // Asynchronous reset while presenting with everything pending.
      for (int i = 0; i < 8; i++) step(3'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_pending", 32'(pending), 32'hFF);
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
      chk("pre_rst_onehot", 32'(out_onehot), 32'h01);
      chk("pre_rst_drop", 32'(drop_cnt), 32'd3);
      drive(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_onehot", 32'(out_onehot), 32'h0);
      chk("async_rst_valid",  32'(out_valid),  32'h0);
      chk("async_rst_pending", 32'(pending),   32'h0);
      chk("async_rst_drop",   32'(drop_cnt),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized run against the reference model.
      apply_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         drive(3'($urandom_range(0, 7)),
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 9) < 4),
               ($urandom_range(0, 39) == 0));
         model_step();
         @(posedge clk);
         #1;
         chk("rnd_onehot", 32'(out_onehot), (m_cur >= 0) ? (32'h1 << m_cur) : 32'h0);
         chk("rnd_valid",  32'(out_valid),  (m_cur >= 0) ? 32'h1 : 32'h0);
         chk("rnd_pending", 32'(pending),   32'(model_pend_vec()));
         chk("rnd_drop",   32'(drop_cnt),   32'(m_drops));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
